// File: rtl/pitch_shift_pkg.sv
// Shared types and constants for the pitch-shift frame sequencer.
//   ps_seq_state_t : sequencer FSM states (accumulate, settle, drain, clear)
//   cbin_t         : complex FFT bin, real part in the upper half, imaginary in the lower
//   SEMI_MIN/MAX   : nominal semitone range understood by the PitchShift LUT
package pitch_shift_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2,
    CLEAR  = 2'd3
  } ps_seq_state_t;

  localparam int BIN_W  = 44;
  localparam int HALF_W = BIN_W / 2;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cbin_t;

  localparam logic signed [4:0] SEMI_MIN = -5'sd12;
  localparam logic signed [4:0] SEMI_MAX = 5'sd12;

endpackage

// File: rtl/pitch_shift_sequencer.sv
// Frame-level controller in front of PitchShift.
// One frame of SAMPLES bins is accepted on the in_* stream and written into
// PitchShift (accumulate), one settle cycle lets the final write land, all
// SAMPLES shifted buckets are then streamed out on out_* (drain), and finally
// the buckets are cleared while any pending semitone change is committed.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last   FFT bin input stream
//   semi_req, semi_req_wr       semitone request and its write strobe
//   ps_en, ps_data_in, ps_input_index   PitchShift accumulate port
//   ps_output_index, ps_data_out        PitchShift read port (combinational read)
//   ps_clr_buckets              PitchShift bucket clear
//   ps_shift, ps_shift_wr_en    PitchShift semitone update
//   out_valid/out_ready/out_data/out_last  shifted bin output stream
//   frame_err                   sticky framing error flag
module pitch_shift_sequencer
  import pitch_shift_pkg::*;
#(
  parameter int SIZE    = 44,
  parameter int SAMPLES = 2048,
  localparam int IDX_W  = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  input  logic             in_last,
  input  logic [4:0]       semi_req,
  input  logic             semi_req_wr,
  output logic             ps_en,
  output logic [SIZE-1:0]  ps_data_in,
  output logic [IDX_W-1:0] ps_input_index,
  output logic [IDX_W-1:0] ps_output_index,
  input  logic [SIZE-1:0]  ps_data_out,
  output logic             ps_clr_buckets,
  output logic [4:0]       ps_shift,
  output logic             ps_shift_wr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic             out_last,
  output logic             frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  ps_seq_state_t    state;
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic [4:0]       pending;
  logic             pending_flag;

  logic in_fire;
  logic out_fire;
  logic wr_last;
  logic rd_last;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign wr_last  = (wr_ptr == LAST_IDX);
  assign rd_last  = (rd_ptr == LAST_IDX);

  // Read side is combinational through PitchShift, so index and data stay
  // stable for as long as rd_ptr holds during a stall.
  assign ps_output_index = rd_ptr;
  assign out_data        = ps_data_out;
  assign out_last        = out_valid & rd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ACCUM;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pending        <= '0;
      pending_flag   <= 1'b0;
      in_ready       <= 1'b1;
      ps_en          <= 1'b0;
      ps_data_in     <= '0;
      ps_input_index <= '0;
      ps_clr_buckets <= 1'b0;
      ps_shift       <= '0;
      ps_shift_wr_en <= 1'b0;
      out_valid      <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      ps_en          <= 1'b0;
      ps_clr_buckets <= 1'b0;
      ps_shift_wr_en <= 1'b0;

      // A request in any cycle replaces the pending value; the commit below
      // (entering CLEAR) overrides the flag so it ends up cleared.
      if (semi_req_wr) begin
        pending      <= semi_req;
        pending_flag <= 1'b1;
      end

      case (state)
        ACCUM: begin
          if (in_fire) begin
            ps_en          <= 1'b1;
            ps_data_in     <= in_data;
            ps_input_index <= wr_ptr;
            // The bin count defines the frame; in_last only flags disagreement.
            if (in_last != wr_last) frame_err <= 1'b1;
            if (wr_last) begin
              wr_ptr   <= '0;
              in_ready <= 1'b0;
              state    <= SETTLE;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end

        SETTLE: begin
          // The final write is on ps_en now; reads start next cycle.
          out_valid <= 1'b1;
          state     <= DRAIN;
        end

        DRAIN: begin
          if (out_fire) begin
            if (rd_last) begin
              rd_ptr         <= '0;
              out_valid      <= 1'b0;
              ps_clr_buckets <= 1'b1;
              state          <= CLEAR;
              // A request arriving on this same edge is the last one before
              // CLEAR, so it takes priority over the stored value.
              if (pending_flag || semi_req_wr) begin
                ps_shift_wr_en <= 1'b1;
                ps_shift       <= semi_req_wr ? semi_req : pending;
                pending_flag   <= 1'b0;
              end
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end

        CLEAR: begin
          in_ready <= 1'b1;
          state    <= ACCUM;
        end

        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_shift_sequencer.sv
// Self-checking bench for pitch_shift_sequencer with a small behavioural
// PitchShift (bucket accumulator) attached behind it.
module tb_pitch_shift_sequencer;
  import pitch_shift_pkg::*;

  localparam int SIZE  = 44;
  localparam int N     = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SIZE-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic [4:0]       semi_req = '0;
  logic             semi_req_wr = 1'b0;
  logic             ps_en;
  logic [SIZE-1:0]  ps_data_in;
  logic [IDX_W-1:0] ps_input_index;
  logic [IDX_W-1:0] ps_output_index;
  logic [SIZE-1:0]  ps_data_out;
  logic             ps_clr_buckets;
  logic [4:0]       ps_shift;
  logic             ps_shift_wr_en;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SIZE-1:0]  out_data;
  logic             out_last;
  logic             frame_err;

  int total = 0;
  int bad   = 0;

  cbin_t frame_in [N];
  cbin_t exp_out  [N];

  // Bench-side view of the semitone handling
  int         b_shift   = 0;
  logic [4:0] b_pending = '0;
  bit         b_flag    = 1'b0;

  always #5 clk = ~clk;

  pitch_shift_sequencer #(.SIZE(SIZE), .SAMPLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .semi_req(semi_req), .semi_req_wr(semi_req_wr),
    .ps_en(ps_en), .ps_data_in(ps_data_in), .ps_input_index(ps_input_index),
    .ps_output_index(ps_output_index), .ps_data_out(ps_data_out),
    .ps_clr_buckets(ps_clr_buckets), .ps_shift(ps_shift), .ps_shift_wr_en(ps_shift_wr_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err)
  );

  // Target bucket of bin k for a shift of s semitones, -1 when it falls off the top.
  function automatic int map_bin(input int k, input int s);
    real r;
    int  t;
    r = real'(k) * (2.0 ** (real'(s) / 12.0));
    t = $rtoi(r + 0.5);
    return (t < N) ? t : -1;
  endfunction

  function automatic cbin_t add_bin(input cbin_t a, input cbin_t b);
    cbin_t r;
    r.re = a.re + b.re;
    r.im = a.im + b.im;
    return r;
  endfunction

  // Behavioural PitchShift
  cbin_t      bucket [N];
  logic [4:0] ps_cur_shift;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (bucket[i]) bucket[i] <= '0;
      ps_cur_shift <= '0;
    end else begin
      if (ps_clr_buckets) begin
        foreach (bucket[i]) bucket[i] <= '0;
      end else if (ps_en) begin
        if (map_bin(int'(ps_input_index), int'($signed(ps_cur_shift))) >= 0)
          bucket[map_bin(int'(ps_input_index), int'($signed(ps_cur_shift)))] <=
            add_bin(bucket[map_bin(int'(ps_input_index), int'($signed(ps_cur_shift)))], ps_data_in);
      end
      if (ps_shift_wr_en) ps_cur_shift <= ps_shift;
    end
  end

  assign ps_data_out = bucket[ps_output_index];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_expected(input int s);
    foreach (exp_out[j]) exp_out[j] = '0;
    for (int k = 0; k < N; k++) begin
      if (map_bin(k, s) >= 0) exp_out[map_bin(k, s)] = add_bin(exp_out[map_bin(k, s)], frame_in[k]);
    end
  endtask

  task automatic random_frame();
    int v;
    for (int i = 0; i < N; i++) begin
      v = int'($urandom_range(2000, 0)) - 1000;
      frame_in[i].re = 22'(v);
      v = int'($urandom_range(2000, 0)) - 1000;
      frame_in[i].im = 22'(v);
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_frame(input int gap_max, input int last_pos,
                            input int semi_at, input logic [4:0] semi_val);
    for (int i = 0; i < N; i++) begin
      int g;
      int waited;
      if (i == semi_at) begin
        semi_req = semi_val; semi_req_wr = 1'b1;
        b_pending = semi_val; b_flag = 1'b1;
        @(posedge clk); #1;
        semi_req_wr = 1'b0;
      end
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_data = frame_in[i]; in_last = (i == last_pos);
      waited = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        waited++;
        if (waited > 50) break;
      end
      if (waited > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout bin=%0d observed=no_ready expected=ready", i);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      chk($sformatf("ps_en_bin%0d", i), ps_en, 1'b1);
      chk($sformatf("ps_idx_bin%0d", i), ps_input_index, i);
      chk($sformatf("ps_din_bin%0d", i), ps_data_in, frame_in[i]);
    end
    chk("in_ready_settle", in_ready, 1'b0);
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random
  task automatic drain_frame(input int mode, input int stop_after,
                             input bit clr_wr, input logic [4:0] clr_val);
    int               fires = 0;
    int               cyc = 0;
    bit               prev_stall = 1'b0;
    logic [IDX_W-1:0] prev_idx = '0;
    logic [SIZE-1:0]  prev_data = '0;
    logic [3:0]       pat = 4'b1001;
    while (fires < stop_after && cyc < 400) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(1, 0));
      @(negedge clk);
      if (out_valid) begin
        chk("in_ready_drain", in_ready, 1'b0);
        if (prev_stall) begin
          chk("stall_idx", ps_output_index, prev_idx);
          chk("stall_data", out_data, prev_data);
        end
        if (out_ready) begin
          chk($sformatf("out_idx%0d", fires), ps_output_index, fires);
          chk($sformatf("out_data%0d", fires), out_data, exp_out[fires]);
          chk($sformatf("out_last%0d", fires), out_last, (fires == N - 1));
          fires++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_idx   = ps_output_index;
          prev_data  = out_data;
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (fires < stop_after) begin
      total++; bad++;
      $display("FAIL drain_timeout observed=%0d expected=%0d", fires, stop_after);
    end
    if (fires == N) begin
      if (clr_wr) begin semi_req = clr_val; semi_req_wr = 1'b1; end
      @(negedge clk);
      chk("clr_pulse", ps_clr_buckets, 1'b1);
      chk("clr_in_ready", in_ready, 1'b0);
      chk("clr_out_valid", out_valid, 1'b0);
      chk("shift_wr_en", ps_shift_wr_en, b_flag);
      if (b_flag) begin
        chk("shift_val", ps_shift, b_pending);
        b_shift = int'($signed(b_pending));
      end
      b_flag = 1'b0;
      if (clr_wr) begin b_pending = clr_val; b_flag = 1'b1; end
      @(posedge clk); #1;
      semi_req_wr = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("clr_done", ps_clr_buckets, 1'b0);
      chk("accum_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ps_en", ps_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_clr", ps_clr_buckets, 1'b0);
    chk("rst_shift_wr", ps_shift_wr_en, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Bypass: shift 0, re=i, im=-i
    for (int i = 0; i < N; i++) begin
      frame_in[i].re = 22'(i);
      frame_in[i].im = 22'(-i);
      exp_out[i] = frame_in[i];
    end
    send_frame(0, N - 1, -1, 5'd0);
    drain_frame(0, N, 1'b0, 5'd0);

    // Semitone timing: 12 requested mid-frame, this frame still unshifted
    for (int i = 0; i < N; i++) begin
      frame_in[i].re = 22'(i + 1);
      frame_in[i].im = '0;
      exp_out[i] = frame_in[i];
    end
    send_frame(1, N - 1, 5, 5'd12);
    drain_frame(0, N, 1'b0, 5'd0);

    // Octave up with backpressure: bin k lands on 2k, upper half dropped
    foreach (exp_out[j]) exp_out[j] = '0;
    for (int k = 0; k < N / 2; k++) exp_out[2 * k].re = 22'(k + 1);
    send_frame(0, N - 1, -1, 5'd0);
    drain_frame(1, N, 1'b0, 5'd0);

    // Request during CLEAR is held for the following boundary
    random_frame();
    build_expected(b_shift);
    send_frame(2, N - 1, -1, 5'd0);
    drain_frame(2, N, 1'b1, 5'b11011);
    // Later write (out-of-range 13) overrides the held one
    random_frame();
    build_expected(b_shift);
    send_frame(2, N - 1, 3, 5'd13);
    drain_frame(2, N, 1'b0, 5'd0);

    // Randomized frames with random in-range shifts
    for (int f = 0; f < 4; f++) begin
      int s;
      s = int'($urandom_range(24, 0)) - 12;
      random_frame();
      build_expected(b_shift);
      send_frame(2, N - 1, int'($urandom_range(N - 1, 0)), 5'(s));
      drain_frame(2, N, 1'b0, 5'd0);
    end

    // Framing error: early in_last on bin 9, count still frames
    chk("ferr_before", frame_err, 1'b0);
    random_frame();
    build_expected(b_shift);
    send_frame(0, 9, -1, 5'd0);
    chk("ferr_set", frame_err, 1'b1);
    drain_frame(0, N, 1'b0, 5'd0);
    random_frame();
    build_expected(b_shift);
    send_frame(1, N - 1, -1, 5'd0);
    drain_frame(0, N, 1'b0, 5'd0);
    chk("ferr_sticky", frame_err, 1'b1);

    // Reset in the middle of a drain
    random_frame();
    build_expected(b_shift);
    send_frame(0, N - 1, -1, 5'd0);
    drain_frame(0, 5, 1'b0, 5'd0);
    chk("pre_rst_idx", ps_output_index, 5);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_idx", ps_output_index, 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    b_shift = 0; b_flag = 1'b0; b_pending = '0;
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_valid", out_valid, 1'b0);
    chk("rel_frame_err", frame_err, 1'b0);
    random_frame();
    build_expected(0);
    send_frame(0, N - 1, -1, 5'd0);
    drain_frame(0, N, 1'b0, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
